// File: rtl/id_ex_hazard_ctrl_pkg.sv
// Shared definitions for the ID/EX hazard controller: FSM state encoding,
// the x0 register index and the sequencing counter width.
package hazard_pkg;

  localparam int CNT_W = 8;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MC_WAIT    = 2'd2,
    FLUSH      = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/id_ex_hazard_ctrl_if.sv
// Control bus between the pipeline and the ID/EX hazard controller.
// The pipeline side uses the master modport, the controller the slave.
// Optional macro HAZARD_PERF_CNT_EN adds the stall/flush perf counters.
interface id_ex_hazard_ctrl_if;

  // ID stage operands
  logic       id_valid;
  logic [4:0] id_rs1;
  logic       id_rs1_used;
  logic [4:0] id_rs2;
  logic       id_rs2_used;
  logic       id_multicycle;

  // EX stage producer and events
  logic       ex_valid;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       mc_done;
  logic       redirect;

  // Sequencing enables back to the pipeline
  logic       pc_stall;
  logic       ifid_stall;
  logic       idex_stall;
  logic       idex_bubble;
  logic       ifid_flush;
  logic       idex_flush;
  logic       mc_start;
  logic       mc_timeout;
  logic [1:0] state_o;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_events;

  modport master (
    output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_multicycle,
    output ex_valid, ex_rd, ex_mem_read, mc_done, redirect,
    input  pc_stall, ifid_stall, idex_stall, idex_bubble, ifid_flush, idex_flush,
    input  mc_start, mc_timeout, state_o, stall_cycles, flush_events
  );

  modport slave (
    input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_multicycle,
    input  ex_valid, ex_rd, ex_mem_read, mc_done, redirect,
    output pc_stall, ifid_stall, idex_stall, idex_bubble, ifid_flush, idex_flush,
    output mc_start, mc_timeout, state_o, stall_cycles, flush_events
  );
`else
  modport master (
    output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_multicycle,
    output ex_valid, ex_rd, ex_mem_read, mc_done, redirect,
    input  pc_stall, ifid_stall, idex_stall, idex_bubble, ifid_flush, idex_flush,
    input  mc_start, mc_timeout, state_o
  );

  modport slave (
    input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_multicycle,
    input  ex_valid, ex_rd, ex_mem_read, mc_done, redirect,
    output pc_stall, ifid_stall, idex_stall, idex_bubble, ifid_flush, idex_flush,
    output mc_start, mc_timeout, state_o
  );
`endif

endinterface

// File: rtl/id_ex_hazard_cmp.sv
// Source/destination register match for one operand. A destination of x0
// never matches, and an operand the instruction does not read never matches.
module hazard_cmp
  import hazard_pkg::*;
(
  input  logic [4:0] src,
  input  logic       src_used,
  input  logic [4:0] dst,
  output logic       match
);

  assign match = src_used & (dst != REG_X0) & (src == dst);

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX pipeline sequencing controller: load-use bubbles, multicycle
// hold with watchdog, and branch-redirect flushes. Outputs are Mealy.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
module id_ex_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_USE_STALL = 1,
  parameter int FLUSH_CYCLES   = 1,
  parameter int MC_MAX_CYCLES  = 32
) (
  input logic              clk,
  input logic              rst,
  id_ex_hazard_ctrl_if.slave bus
);

  localparam cnt_t LUS_LAST   = cnt_t'(LOAD_USE_STALL - 1);
  localparam cnt_t FLUSH_LAST = cnt_t'(FLUSH_CYCLES - 1);
  localparam cnt_t MC_LAST    = cnt_t'(MC_MAX_CYCLES - 1);
  localparam bit   LUS_MULTI   = (LOAD_USE_STALL > 1);
  localparam bit   FLUSH_MULTI = (FLUSH_CYCLES > 1);

  ctrl_state_e state, state_n;
  cnt_t        cnt, cnt_n;
  logic        timeout_q, timeout_n;

  logic rs1_hit, rs2_hit, hazard;
  logic pc_stall, ifid_stall, idex_stall, idex_bubble;
  logic ifid_flush, idex_flush, mc_start;

  hazard_cmp u_cmp_rs1 (
    .src      (bus.id_rs1),
    .src_used (bus.id_rs1_used),
    .dst      (bus.ex_rd),
    .match    (rs1_hit)
  );

  hazard_cmp u_cmp_rs2 (
    .src      (bus.id_rs2),
    .src_used (bus.id_rs2_used),
    .dst      (bus.ex_rd),
    .match    (rs2_hit)
  );

  assign hazard = bus.id_valid & bus.ex_valid & bus.ex_mem_read & (rs1_hit | rs2_hit);

  // Next state and Mealy enables; redirect outranks every state's own work
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    timeout_n   = timeout_q;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    mc_start    = 1'b0;
    if (!rst) begin
      if (bus.redirect) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        cnt_n      = cnt_t'(1);
        state_n    = FLUSH_MULTI ? FLUSH : RUN;
      end else begin
        case (state)
          RUN: begin
            if (hazard) begin
              pc_stall    = 1'b1;
              ifid_stall  = 1'b1;
              idex_bubble = 1'b1;
              cnt_n       = cnt_t'(1);
              state_n     = LUS_MULTI ? LOAD_STALL : RUN;
            end else if (bus.id_valid && bus.id_multicycle) begin
              mc_start = 1'b1;
              cnt_n    = '0;
              state_n  = MC_WAIT;
            end
          end
          LOAD_STALL: begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
            cnt_n       = cnt + cnt_t'(1);
            if (cnt == LUS_LAST) state_n = RUN;
          end
          MC_WAIT: begin
            if (bus.mc_done) begin
              state_n = RUN;
            end else if (cnt == MC_LAST) begin
              timeout_n = 1'b1;
              state_n   = RUN;
            end else begin
              pc_stall   = 1'b1;
              ifid_stall = 1'b1;
              idex_stall = 1'b1;
              cnt_n      = cnt + cnt_t'(1);
            end
          end
          FLUSH: begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            cnt_n      = cnt + cnt_t'(1);
            if (cnt == FLUSH_LAST) state_n = RUN;
          end
          default: state_n = RUN;
        endcase
      end
    end
  end

  // State, sequencing counter and sticky watchdog flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      timeout_q <= timeout_n;
    end
  end

  assign bus.pc_stall    = pc_stall;
  assign bus.ifid_stall  = ifid_stall;
  assign bus.idex_stall  = idex_stall;
  assign bus.idex_bubble = idex_bubble;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = idex_flush;
  assign bus.mc_start    = mc_start;
  assign bus.mc_timeout  = timeout_q;
  assign bus.state_o     = state;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] flush_events_q;

  // Saturating counts of PC-stall cycles and redirect cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (pc_stall && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (bus.redirect && (flush_events_q != '1)) flush_events_q <= flush_events_q + 16'd1;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Self-checking bench for id_ex_hazard_ctrl: directed scenarios followed by
// random traffic, compared each cycle against a behavioural model.
module tb_id_ex_hazard_ctrl;

  localparam int LUS = 3;
  localparam int FLC = 2;
  localparam int MCM = 12;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  id_ex_hazard_ctrl_if bus ();

  id_ex_hazard_ctrl #(
    .LOAD_USE_STALL (LUS),
    .FLUSH_CYCLES   (FLC),
    .MC_MAX_CYCLES  (MCM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: remaining work expressed as counts of cycles still owed
  int  bub_left;
  int  flush_left;
  bit  mc_busy;
  int  mc_elapsed;
  bit  m_timeout;
  longint stall_total;
  longint flush_total;

  task automatic model_reset();
    bub_left    = 0;
    flush_left  = 0;
    mc_busy     = 1'b0;
    mc_elapsed  = 0;
    m_timeout   = 1'b0;
    stall_total = 0;
    flush_total = 0;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input bit iv, input logic [4:0] r1, input bit u1,
                                input logic [4:0] r2, input bit u2, input bit imc,
                                input bit ev, input logic [4:0] rd, input bit mr,
                                input bit done, input bit redir);
    bus.id_valid      = iv;
    bus.id_rs1        = r1;
    bus.id_rs1_used   = u1;
    bus.id_rs2        = r2;
    bus.id_rs2_used   = u2;
    bus.id_multicycle = imc;
    bus.ex_valid      = ev;
    bus.ex_rd         = rd;
    bus.ex_mem_read   = mr;
    bus.mc_done       = done;
    bus.redirect      = redir;
  endtask

  task automatic set_idle();
    apply_stimulus(0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0);
  endtask

  // One cycle: inputs are already driven; check settled outputs, advance model
  task automatic step(input string tag);
    bit ps, is, xs, bub, ff, xf, ms, hz;
    logic [1:0] exp_state;
    logic [7:0] exp_vec, obs_vec;
    bit exp_to;
    longint exp_stalls, exp_flushes;
    ps = 0; is = 0; xs = 0; bub = 0; ff = 0; xf = 0; ms = 0;
    #1;
    if (rst) model_reset();
    if (flush_left > 0)    exp_state = 2'd3;
    else if (bub_left > 0) exp_state = 2'd1;
    else if (mc_busy)      exp_state = 2'd2;
    else                   exp_state = 2'd0;
    exp_to      = m_timeout;
    exp_stalls  = stall_total;
    exp_flushes = flush_total;
    hz = bus.id_valid && bus.ex_valid && bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
         ((bus.id_rs1_used && bus.id_rs1 == bus.ex_rd) ||
          (bus.id_rs2_used && bus.id_rs2 == bus.ex_rd));
    if (!rst) begin
      if (bus.redirect) begin
        ff = 1; xf = 1;
        flush_left = FLC - 1;
        bub_left   = 0;
        mc_busy    = 0;
      end else if (flush_left > 0) begin
        ff = 1; xf = 1;
        flush_left--;
      end else if (bub_left > 0) begin
        ps = 1; is = 1; bub = 1;
        bub_left--;
      end else if (mc_busy) begin
        if (bus.mc_done) mc_busy = 0;
        else if (mc_elapsed == MCM - 1) begin
          mc_busy = 0;
          m_timeout = 1;
        end else begin
          ps = 1; is = 1; xs = 1;
          mc_elapsed++;
        end
      end else if (hz) begin
        ps = 1; is = 1; bub = 1;
        bub_left = LUS - 1;
      end else if (bus.id_valid && bus.id_multicycle) begin
        ms = 1;
        mc_busy = 1;
        mc_elapsed = 0;
      end
    end
    exp_vec = {ps, is, xs, bub, ff, xf, ms, exp_to};
    obs_vec = {bus.pc_stall, bus.ifid_stall, bus.idex_stall, bus.idex_bubble,
               bus.ifid_flush, bus.idex_flush, bus.mc_start, bus.mc_timeout};
    check_output({tag, ".outs"}, 32'(obs_vec), 32'(exp_vec));
    check_output({tag, ".state"}, 32'(bus.state_o), 32'(exp_state));
`ifdef HAZARD_PERF_CNT_EN
    check_output({tag, ".stall_cycles"}, bus.stall_cycles, 32'(exp_stalls));
    check_output({tag, ".flush_events"}, 32'(bus.flush_events), 32'(exp_flushes));
`endif
    if (!rst) begin
      if (ps && stall_total < 64'hFFFF_FFFF) stall_total++;
      if (bus.redirect && flush_total < 64'hFFFF) flush_total++;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    set_idle();
    @(negedge clk);
    $display("[TB] reset state");
    step("reset0");
    step("reset1");
    rst = 1'b0;
    step("idle");

    $display("[TB] load-use hazard");
    apply_stimulus(1, 5'd3, 1, 5'd5, 1, 0, 1, 5'd5, 1, 0, 0);
    step("lu_detect");
    apply_stimulus(1, 5'd3, 1, 5'd5, 1, 0, 0, 5'd0, 0, 0, 0);
    step("lu_bubble2");
    step("lu_bubble3");
    step("lu_release");
    set_idle();
    step("lu_idle");

    $display("[TB] x0, unused operand, non-load");
    apply_stimulus(1, 5'd0, 1, 5'd4, 0, 0, 1, 5'd0, 1, 0, 0);
    step("x0_dest");
    apply_stimulus(1, 5'd7, 0, 5'd2, 1, 0, 1, 5'd7, 1, 0, 0);
    step("rs1_unused");
    apply_stimulus(1, 5'd9, 1, 5'd9, 1, 0, 1, 5'd9, 0, 0, 0);
    step("not_load");
    apply_stimulus(0, 5'd9, 1, 5'd9, 1, 0, 1, 5'd9, 1, 0, 0);
    step("id_invalid");

    $display("[TB] multicycle with done");
    apply_stimulus(1, 5'd1, 1, 5'd2, 1, 1, 0, 5'd0, 0, 0, 0);
    step("mc_issue");
    set_idle();
    for (int i = 0; i < 9; i++) step("mc_wait");
    bus.mc_done = 1;
    step("mc_done");
    set_idle();
    step("mc_after");

    $display("[TB] multicycle watchdog");
    apply_stimulus(1, 5'd1, 1, 5'd2, 1, 1, 0, 5'd0, 0, 0, 0);
    step("wd_issue");
    set_idle();
    for (int i = 0; i < MCM; i++) step("wd_wait");
    bus.mc_done = 1;
    step("wd_late_done");
    set_idle();
    step("wd_sticky");

    $display("[TB] redirect priority");
    apply_stimulus(1, 5'd6, 1, 5'd0, 0, 0, 1, 5'd6, 1, 0, 1);
    step("redir_vs_hazard");
    set_idle();
    step("redir_flush2");
    step("redir_done");
    apply_stimulus(1, 5'd1, 1, 5'd2, 1, 1, 0, 5'd0, 0, 0, 0);
    step("mcr_issue");
    set_idle();
    step("mcr_wait");
    bus.mc_done  = 1;
    bus.redirect = 1;
    step("mcr_redirect");
    set_idle();
    step("mcr_flush");
    step("mcr_run");

    $display("[TB] async reset in MC_WAIT");
    apply_stimulus(1, 5'd1, 1, 5'd2, 1, 1, 0, 5'd0, 0, 0, 0);
    step("ar_issue");
    set_idle();
    step("ar_wait");
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_output("ar_outs", 32'({bus.pc_stall, bus.ifid_stall, bus.idex_stall, bus.idex_bubble,
                                 bus.ifid_flush, bus.idex_flush, bus.mc_start, bus.mc_timeout}), 32'd0);
    check_output("ar_state", 32'(bus.state_o), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check_output("ar_stall_cycles", bus.stall_cycles, 32'd0);
    check_output("ar_flush_events", 32'(bus.flush_events), 32'd0);
`endif
    @(negedge clk);
    step("ar_held");
    rst = 1'b0;
    bus.mc_done = 1;
    step("ar_stale_done");
    set_idle();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(($urandom_range(0, 3) != 0),
                     5'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                     5'($urandom_range(0, 3)), ($urandom_range(0, 1) != 0),
                     ($urandom_range(0, 5) == 0),
                     ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
                     ($urandom_range(0, 1) != 0),
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
